reram_activation_unit: RTL and testbench

RERAM_ACTIVATION_UNIT -- requirements
Module: reram_activation_unit

---
 rtl/reram_activation_unit.sv | 197 +++++++++++++++++++
 tb/tb_reram_activation_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reram_activation_unit.sv
// ----------------------------------------------------------------------------
// reram_activation_unit
//   Post-processing for ReRAM crossbar results. Each accepted result has the
//   crossbar zero point removed, goes through ReLU, is scaled down by a right
//   shift and saturated, then is queued in a small output FIFO with its neuron
//   index. A running argmax over the activated values of one inference is kept
//   and published with a one-cycle result_valid pulse when the inference ends.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin an inference (honoured only in IDLE)
//   in_data/in_addr       crossbar result and its neuron index
//   in_valid              result present this cycle (no backpressure)
//   ctrl_done             upstream end-of-inference pulse (honoured in ACTIVE)
//   out_data/out_addr     FIFO head (activated value, neuron index)
//   out_valid/out_ready   FIFO handshake
//   argmax_idx/argmax_val largest activated value of the inference so far
//   result_valid          one-cycle pulse, argmax outputs are final
//   busy                  inference in progress (ACTIVE or DRAIN)
//   overflow              sticky, a result was dropped on a full FIFO
// ----------------------------------------------------------------------------
module reram_activation_unit #(
    parameter int IN_WIDTH    = 12,
    parameter int OUT_WIDTH   = 8,
    parameter int NUM_NEURONS = 256,
    parameter int ZERO_POINT  = 2048,
    parameter int SHIFT       = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [7:0]           in_addr,
    input  logic                 in_valid,
    input  logic                 ctrl_done,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [7:0]           out_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           argmax_idx,
    output logic [OUT_WIDTH-1:0] argmax_val,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 overflow
);

    localparam int CW = $clog2(NUM_NEURONS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [IN_WIDTH:0]  ZP       = (IN_WIDTH + 1)'(ZERO_POINT);
    localparam logic [CW-1:0]      LAST_CNT = CW'(NUM_NEURONS - 1);
    localparam logic [AW:0]        FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       acc_cnt;

    // stage 1 registers (after subtract/ReLU)
    logic                s1_vld;
    logic [IN_WIDTH-1:0] s1_val;
    logic [7:0]          s1_addr;

    // output FIFO
    logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [7:0]           mem_addr [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          fifo_cnt;
    logic                 am_seen;

    logic                 accept, last_acc, start_acc;
    logic                 full, pop, do_push;
    logic [IN_WIDTH:0]    diff;
    logic [IN_WIDTH-1:0]  relu, shifted;
    logic [OUT_WIDTH-1:0] act;

    assign accept    = (state == ACTIVE) && in_valid;
    assign last_acc  = accept && (acc_cnt == LAST_CNT);
    assign start_acc = (state == IDLE) && start;

    // Zero-point removal in IN_WIDTH+1 bits: the extra MSB is the sign.
    assign diff = {1'b0, in_data} - ZP;
    assign relu = diff[IN_WIDTH] ? '0 : diff[IN_WIDTH-1:0];

    assign shifted = s1_val >> SHIFT;
    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_sat
            assign act = (|shifted[IN_WIDTH-1:OUT_WIDTH]) ? '1 : shifted[OUT_WIDTH-1:0];
        end else begin : g_nosat
            assign act = OUT_WIDTH'(shifted);
        end
    endgenerate

    assign out_valid = (fifo_cnt != '0);
    assign full      = (fifo_cnt == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push   = s1_vld && (!full || pop);

    // Gate the head with out_valid so an empty FIFO (and reset) shows zeros.
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_addr = out_valid ? mem_addr[rd_ptr] : '0;

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACTIVE;
                        acc_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (accept)
                        acc_cnt <= acc_cnt + 1'b1;
                    if (last_acc || ctrl_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // stage 1 empty and nothing queued: every result has left
                    if (!s1_vld && fifo_cnt == '0) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: stage 1, FIFO pointers/count, argmax, overflow.
    // Stage 2 (shift/saturate) writes straight into the FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_val     <= '0;
            s1_addr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow   <= 1'b0;
            argmax_idx <= '0;
            argmax_val <= '0;
            am_seen    <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_val  <= relu;
                s1_addr <= in_addr;
            end

            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase

            if (start_acc) begin
                overflow   <= 1'b0;
                argmax_idx <= '0;
                argmax_val <= '0;
                am_seen    <= 1'b0;
            end else if (s1_vld) begin
                if (full && !pop)
                    overflow <= 1'b1;
                // strict compare keeps the earliest index on ties;
                // am_seen makes the first result load even when it is 0
                if (!am_seen || act > argmax_val) begin
                    argmax_idx <= s1_addr;
                    argmax_val <= act;
                    am_seen    <= 1'b1;
                end
            end
        end
    end

    // FIFO storage, no reset needed: reads are masked by out_valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= act;
            mem_addr[wr_ptr] <= s1_addr;
        end
    end

endmodule

// File: tb/tb_reram_activation_unit.sv
// ----------------------------------------------------------------------------
// tb_reram_activation_unit
//   Randomised and directed bench with a cycle-level behavioural model. The
//   model pushes each expected FIFO entry into a scoreboard queue; a monitor
//   pops and compares whenever the DUT hands an entry downstream, and checks
//   status outputs against the model every cycle.
// ----------------------------------------------------------------------------
module tb_reram_activation_unit;

    localparam int IW = 12, OW = 8, NN = 256, ZP = 2048, SH = 3, FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic [7:0]    in_addr = '0;
    logic          in_valid = 1'b0;
    logic          ctrl_done = 1'b0;
    logic [OW-1:0] out_data;
    logic [7:0]    out_addr;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    argmax_idx;
    logic [OW-1:0] argmax_val;
    logic          result_valid;
    logic          busy;
    logic          overflow;

    reram_activation_unit #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_NEURONS(NN),
        .ZERO_POINT(ZP), .SHIFT(SH), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_addr(in_addr), .in_valid(in_valid), .ctrl_done(ctrl_done),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .argmax_idx(argmax_idx), .argmax_val(argmax_val),
        .result_valid(result_valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rv_count = 0;
    int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int act_ref(input int x);
        int d;
        d = x - ZP;
        if (d < 0) return 0;
        d = d / (1 << SH);
        if (d > (1 << OW) - 1) d = (1 << OW) - 1;
        return d;
    endfunction

    // ---------------- behavioural model ----------------
    int mst = 0;          // 0 idle, 1 active, 2 drain, 3 done
    int m_cnt = 0;        // results accepted this inference
    int mcnt = 0;         // FIFO occupancy
    bit p1_v = 0;         // result accepted on the previous edge
    int p1_a = 0, p1_d = 0;
    bit m_ovf = 0, m_seen = 0;
    int m_ai = 0, m_av = 0;
    int sb_a[$];
    int sb_d[$];

    always @(posedge clk) begin
        bit was_p1, was_empty;
        if (!rst_n) begin
            mst = 0; m_cnt = 0; mcnt = 0; p1_v = 0;
            m_ovf = 0; m_seen = 0; m_ai = 0; m_av = 0;
            sb_a.delete(); sb_d.delete();
        end else begin
            was_p1    = p1_v;
            was_empty = (mcnt == 0);
            if (mcnt > 0 && out_ready) mcnt--;
            if (p1_v) begin
                if (mcnt < FD) begin
                    sb_a.push_back(p1_a); sb_d.push_back(p1_d); mcnt++;
                end else m_ovf = 1;
                if (!m_seen || p1_d > m_av) begin
                    m_seen = 1; m_av = p1_d; m_ai = p1_a;
                end
            end
            p1_v = 0;
            case (mst)
                0: if (start) begin
                    mst = 1; m_cnt = 0; m_ovf = 0; m_seen = 0; m_av = 0; m_ai = 0;
                end
                1: begin
                    if (in_valid) begin
                        p1_v = 1; p1_a = in_addr; p1_d = act_ref(in_data); m_cnt++;
                    end
                    if ((in_valid && m_cnt == NN) || ctrl_done) mst = 2;
                end
                2: if (!was_p1 && was_empty) mst = 3;
                default: mst = 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, mcnt > 0);
            chk("busy", busy, (mst == 1 || mst == 2));
            chk("result_valid", result_valid, mst == 3);
            chk("overflow", overflow, m_ovf);
            if (result_valid) begin
                rv_count++;
                chk("argmax_idx", argmax_idx, m_ai);
                chk("argmax_val", argmax_val, m_av);
            end
            if (out_valid && out_ready) begin
                if (sb_a.size() == 0) chk("pop_unexpected", 1, 0);
                else begin
                    chk("out_addr", out_addr, sb_a.pop_front());
                    chk("out_data", out_data, sb_d.pop_front());
                end
            end
        end
    end

    // out_ready driver
    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send(input int addr, input int data);
        in_valid = 1'b1; in_addr = 8'(addr); in_data = IW'(data);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_done();
        ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
    endtask

    task automatic wait_rv(input int bound);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (result_valid) begin got = 1; break; end
        end
        chk("done_timeout", got, 1);
    endtask

    initial begin
        int rv0, n, sent;

        // reset: outputs forced to zero immediately
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_argmax_idx", argmax_idx, 0);
        chk("rst_argmax_val", argmax_val, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // inputs in IDLE are ignored
        send(1, 3000);
        finish_done();
        repeat (2) tick();

        // basic activation and two-cycle latency
        rdy_mode = 1;
        tick();
        do_start();
        in_valid = 1'b1; in_addr = 8'd5; in_data = IW'(2148);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 12);
        chk("lat_addr", out_addr, 5);
        tick();
        send(6, 1000);
        send(7, 4095);
        send(8, 2048);
        finish_done();
        wait_rv(50);
        tick();

        // full inference of NN results, tie at the maximum
        rv0 = rv_count;
        do_start();
        for (int i = 0; i < NN; i++) begin
            in_valid = 1'b1; in_addr = 8'(i);
            in_data = IW'((i == 3 || i == 9) ? 2148 : $urandom_range(0, 2143));
            tick();
        end
        in_valid = 1'b0;
        wait_rv(50);
        chk("full_argmax_idx", argmax_idx, 3);
        chk("full_argmax_val", argmax_val, 12);
        repeat (3) tick();
        chk("full_rv_pulses", rv_count - rv0, 1);

        // overflow with a stalled consumer
        rdy_mode = 0;
        do_start();
        for (int i = 0; i < 6; i++) send(20 + i, 2048 + 8 * i);
        repeat (3) tick();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_held", out_valid, 1);
        finish_done();
        repeat (2) tick();
        rdy_mode = 1;
        wait_rv(50);
        tick();

        // early ctrl_done after 10 results, random consumer
        rdy_mode = 2;
        do_start();
        for (int i = 0; i < 10; i++) send(100 + i, $urandom_range(0, 4095));
        finish_done();
        wait_rv(200);
        tick();
        chk("drain_busy_low", busy, 0);

        // reset during ACTIVE with 3 entries queued
        rdy_mode = 0;
        tick();
        do_start();
        for (int i = 0; i < 3; i++) send(40 + i, 2500);
        repeat (3) tick();
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rdy_mode = 1;
        rv0 = rv_count;
        repeat (20) tick();
        chk("no_rv_after_rst", rv_count - rv0, 0);

        // randomised inferences with noise outside ACTIVE
        for (int k = 0; k < 12; k++) begin
            rdy_mode = (k % 3 == 0) ? 0 : 2;
            if ($urandom_range(0, 1)) finish_done();
            do_start();
            n = $urandom_range(1, 40);
            sent = 0;
            while (sent < n) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_addr  = 8'($urandom_range(0, 255));
                in_data  = IW'($urandom_range(0, 4095));
                start    = ($urandom_range(0, 7) == 0);
                if (in_valid) sent++;
                tick();
            end
            in_valid = 1'b0; start = 1'b0;
            finish_done();
            for (int j = 0; j < 2; j++) send($urandom_range(0, 255), $urandom_range(0, 4095));
            rdy_mode = 2;
            wait_rv(400);
            tick();
        end

        repeat (5) tick();
        chk("scoreboard_empty", sb_a.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
